// File: rtl/simon_pkg.sv
// simon_pkg
//   Shared constants and types for the Simon game datapath and its control.
//   PAT_W  : width of one pattern (switches / LEDs)
//   ADDR_W : pointer width; the sequence store holds DEPTH = 2**ADDR_W entries
//   led_mode_e : LED mode encodings used by the control FSM
package simon_pkg;

  localparam int PAT_W  = 4;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    INPUT    = 3'b001,
    PLAYBACK = 3'b010,
    REPEAT   = 3'b100,
    DONE     = 3'b111
  } led_mode_e;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  function automatic logic is_one_hot(input logic [PAT_W-1:0] p);
    return (p != '0) && ((p & (p - PAT_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/simon_datapath_if.sv
// simon_datapath_if
//   Control/status handshake between the Simon control FSM and its datapath.
//   Strobes (control -> datapath): last_inc, i_inc, i_clr, mem_ld, s_led_eq_pat
//   Status  (datapath -> control): i_lt_last, arr_full, correct_pat, legal
//   master : control FSM side
//   slave  : datapath side
interface simon_datapath_if;

  logic last_inc;
  logic i_inc;
  logic i_clr;
  logic mem_ld;
  logic s_led_eq_pat;
  logic i_lt_last;
  logic arr_full;
  logic correct_pat;
  logic legal;

  modport master (
    output last_inc, i_inc, i_clr, mem_ld, s_led_eq_pat,
    input  i_lt_last, arr_full, correct_pat, legal
  );

  modport slave (
    input  last_inc, i_inc, i_clr, mem_ld, s_led_eq_pat,
    output i_lt_last, arr_full, correct_pat, legal
  );

endinterface

// File: rtl/simon_regfile.sv
// simon_regfile
//   DEPTH x PAT_W pattern store, no reset.
//   clk            : write clock
//   we/waddr/wdata : synchronous write port
//   raddr0/rdata0  : asynchronous read port (pattern compare)
//   raddr1/rdata1  : asynchronous read port (LED playback)
//   A read of the address being written returns the old contents this cycle.
module simon_regfile
  import simon_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PAT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [PAT_W-1:0]  rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [PAT_W-1:0]  rdata1
);

  logic [PAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/simon_datapath.sv
// simon_datapath
//   Datapath for the Simon game: stores the recorded sequence and walks it.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset (clears the pointers only)
//   pattern      : live switch pattern, already synchronised
//   ctrl         : control strobes in / status out (simon_datapath_if.slave)
//   pattern_leds : LED drive, live pattern or stored entry i
//   level        : number of stored entries (last+1), for the score display
module simon_datapath
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PAT_W-1:0]    pattern,
  simon_datapath_if.slave     ctrl,
  output logic [PAT_W-1:0]    pattern_leds,
  output logic [ADDR_W:0]     level
);

  logic [ADDR_W-1:0] last;
  logic [ADDR_W-1:0] i;
  logic [PAT_W-1:0]  cmp_data;
  logic [PAT_W-1:0]  led_data;
  logic              full;
  logic              legal;

  assign legal = is_one_hot(pattern);
  assign full  = &last;

  simon_regfile u_regfile (
    .clk    (clk),
    .we     (ctrl.mem_ld && legal),
    .waddr  (last),
    .wdata  (pattern),
    .raddr0 (i),
    .rdata0 (cmp_data),
    .raddr1 (i),
    .rdata1 (led_data)
  );

  // i wraps against the old value of last, so a simultaneous last_inc
  // does not change where i lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= '0;
      i    <= '0;
    end else begin
      if (ctrl.last_inc && !full) last <= last + ADDR_W'(1);
      if (ctrl.i_clr)             i <= '0;
      else if (ctrl.i_inc)        i <= (i == last) ? '0 : i + ADDR_W'(1);
    end
  end

  assign ctrl.i_lt_last   = (i < last);
  assign ctrl.arr_full    = full;
  assign ctrl.correct_pat = (pattern == cmp_data);
  assign ctrl.legal       = legal;

  assign pattern_leds = ctrl.s_led_eq_pat ? pattern : led_data;
  assign level        = {1'b0, last} + (ADDR_W+1)'(1);

endmodule

// File: tb/tb_simon_datapath.sv
// tb_simon_datapath
//   Self-checking bench for simon_datapath. Expected values are pushed to a
//   scoreboard queue as stimulus is applied and popped when outputs are read.
module tb_simon_datapath;
  import simon_pkg::*;

  logic              clk;
  logic              rst;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  pattern_leds;
  logic [ADDR_W:0]   level;

  simon_datapath_if bus ();

  simon_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .pattern      (pattern),
    .ctrl         (bus.slave),
    .pattern_leds (pattern_leds),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t scoreboard [$];
  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectVal(input string tag, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    scoreboard.push_back(it);
  endtask

  task automatic checkNext(input logic [31:0] obs);
    sb_item_t it;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", obs, 32'hDEAD_BEEF);
    end else begin
      it = scoreboard.pop_front();
      checkOutput(it.tag, obs, it.val);
    end
  endtask

  task automatic applyStimulus(input logic li, input logic ii, input logic ic,
                               input logic ml, input logic [PAT_W-1:0] pat);
    bus.last_inc = li;
    bus.i_inc    = ii;
    bus.i_clr    = ic;
    bus.mem_ld   = ml;
    pattern      = pat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic li, input logic ii, input logic ic,
                       input logic ml, input logic [PAT_W-1:0] pat);
    applyStimulus(li, ii, ic, ml, pat);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, pat);
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    expectVal("rst_level", 32'd1);      checkNext(32'(level));
    expectVal("rst_i_lt_last", 32'd0);  checkNext(32'(bus.i_lt_last));
    expectVal("rst_arr_full", 32'd0);   checkNext(32'(bus.arr_full));
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.s_led_eq_pat = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    #3;
    expectVal("por_level", 32'd1);      checkNext(32'(level));
    expectVal("por_i_lt_last", 32'd0);  checkNext(32'(bus.i_lt_last));
    expectVal("por_arr_full", 32'd0);   checkNext(32'(bus.arr_full));
    @(negedge clk);
    rst = 1'b1;

    // one-hot detection
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    expectVal("legal_0100", 32'd1);  checkNext(32'(bus.legal));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    expectVal("legal_0110", 32'd0);  checkNext(32'(bus.legal));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectVal("legal_0000", 32'd0);  checkNext(32'(bus.legal));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    expectVal("legal_1000", 32'd1);  checkNext(32'(bus.legal));

    // build {0001, 1000}; an illegal write must not disturb entry 0
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    expectVal("illegal_no_write", 32'h1);  checkNext(32'(pattern_leds));
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    expectVal("build_level", 32'd2);  checkNext(32'(level));

    bus.s_led_eq_pat = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    expectVal("leds_live", 32'h2);  checkNext(32'(pattern_leds));
    bus.s_led_eq_pat = 1'b0;
    #1;
    expectVal("play0_leds", 32'h1);  checkNext(32'(pattern_leds));
    expectVal("play0_lt", 32'd1);    checkNext(32'(bus.i_lt_last));
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
    expectVal("play1_leds", 32'h8);  checkNext(32'(pattern_leds));
    expectVal("play1_lt", 32'd0);    checkNext(32'(bus.i_lt_last));
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
    expectVal("play2_leds", 32'h1);  checkNext(32'(pattern_leds));
    expectVal("play2_lt", 32'd1);    checkNext(32'(bus.i_lt_last));

    // restart pointers, build {0010, 0100}, compare at i=1
    asyncReset();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);
    expectVal("cmp_match", 32'd1);  checkNext(32'(bus.correct_pat));
    expectVal("cmp_lt", 32'd0);     checkNext(32'(bus.i_lt_last));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    expectVal("cmp_miss", 32'd0);   checkNext(32'(bus.correct_pat));
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    expectVal("both_level", 32'd3);  checkNext(32'(level));
    expectVal("both_i_zero", 32'h2); checkNext(32'(pattern_leds));
    expectVal("both_lt", 32'd1);     checkNext(32'(bus.i_lt_last));

    // entries 2,3 = 1000, 0001; walk i to 3 then clear with i_inc also set
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    expectVal("i3_leds", 32'h1);  checkNext(32'(pattern_leds));
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    expectVal("prio_clr", 32'h2);  checkNext(32'(pattern_leds));

    // mid-run reset with last=5, i=3
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 3; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    expectVal("pre_rst_level", 32'd6);  checkNext(32'(level));
    expectVal("pre_rst_leds", 32'h1);   checkNext(32'(pattern_leds));
    asyncReset();
    expectVal("post_rst_mem", 32'h2);  checkNext(32'(pattern_leds));

    // read-during-write returns old data until the edge
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    expectVal("rdw_old", 32'h2);      checkNext(32'(pattern_leds));
    expectVal("rdw_old_cmp", 32'd0);  checkNext(32'(bus.correct_pat));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    expectVal("rdw_new", 32'h4);      checkNext(32'(pattern_leds));
    expectVal("rdw_new_cmp", 32'd1);  checkNext(32'(bus.correct_pat));

    // fill to the top of the store
    for (int k = 0; k < 62; k++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectVal("l62_level", 32'd63);  checkNext(32'(level));
    expectVal("l62_full", 32'd0);    checkNext(32'(bus.arr_full));
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectVal("l63_level", 32'd64);  checkNext(32'(level));
    expectVal("l63_full", 32'd1);    checkNext(32'(bus.arr_full));
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectVal("sat_level", 32'd64);  checkNext(32'(level));
    expectVal("sat_full", 32'd1);    checkNext(32'(bus.arr_full));
    for (int k = 0; k < 62; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    expectVal("i62_lt", 32'd1);  checkNext(32'(bus.i_lt_last));
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    expectVal("i63_lt", 32'd0);  checkNext(32'(bus.i_lt_last));
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    expectVal("i_wrap_lt", 32'd1);    checkNext(32'(bus.i_lt_last));
    expectVal("i_wrap_leds", 32'h4);  checkNext(32'(pattern_leds));

    if (scoreboard.size() != 0)
      checkOutput("scoreboard_left", 32'(scoreboard.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath for the Simon game. It is the counterpart of the Simon control FSM: it consumes that FSM's control strobes (last_inc, i_inc, i_clr, mem_ld, s_led_eq_pat) and produces its status inputs (i_lt_last, arr_full, correct_pat, legal).
- It holds the recorded pattern sequence in a register file, plus two pointers:
  - last: index of the newest stored entry.
  - i: playback/compare index.
- It drives the pattern LEDs from either the live switches or the stored sequence.

Parameters:
- PAT_W, 4, width of one pattern (number of switches/LEDs).
- ADDR_W, 6, pointer width; register-file depth is 2**ADDR_W (64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- pattern  input  PAT_W  live pattern switches (already synchronised upstream).
- last_inc  input  1  increment last.
- i_inc  input  1  advance i.
- i_clr  input  1  clear i to 0.
- mem_ld  input  1  request write of pattern into entry last.
- s_led_eq_pat  input  1  1: LEDs show pattern; 0: LEDs show entry i.
- i_lt_last  output  1  i < last (unsigned).
- arr_full  output  1  last == 2**ADDR_W-1.
- correct_pat  output  1  pattern == mem[i].
- legal  output  1  pattern is one-hot (exactly one bit set).
- pattern_leds  output  PAT_W  LED drive.
- level  output  ADDR_W+1  number of stored entries, last+1 (score display).

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-edge release):
  - last=0, i=0.
  - Register-file contents are not reset.
  - Resulting outputs: i_lt_last=0, arr_full=0, level=1.
  - correct_pat and pattern_leds in LED-memory mode are undefined until entry 0 is written.
  - Reset may assert mid-sequence and must clear both pointers the same cycle, independent of clk.
- Write:
  - mem[last] <= pattern on a clock edge when mem_ld && legal.
  - mem_ld with an illegal pattern writes nothing.
  - Writing the same entry repeatedly while mem_ld is held is permitted; the last legal value wins.
- last pointer:
  - On last_inc, last <= last+1, saturating at 2**ADDR_W-1. No wrap; the control never requests an increment when arr_full.
- i pointer, priority i_clr > i_inc:
  - i_clr: i <= 0.
  - i_inc with i == last: i <= 0 (wrap to start of stored sequence, not to 2**ADDR_W).
  - i_inc otherwise: i <= i+1.
  - Neither strobe: hold.
  - The wrap guarantees that the final PLAYBACK cycle leaves i=0 for REPEAT, and that the DONE state loops the sequence endlessly.
- Simultaneous last_inc and i_inc (REPEAT, correct final entry): both take effect the same edge. i wraps to 0 against the old last; last becomes last+1.
- Status outputs are purely combinational from current registers and the pattern input, with zero latency:
  - i_lt_last = (i < last) unsigned.
  - arr_full = &last.
  - correct_pat = (pattern == mem[i]); asynchronous read port.
  - legal = pattern!=0 && (pattern & (pattern-1))==0.
- pattern_leds = s_led_eq_pat ? pattern : mem[i]. Combinational, same-cycle.
- Read-during-write on the same address returns old data; the new data is visible the next cycle.
- Widths:
  - All pointer arithmetic is ADDR_W bits; compares are unsigned.
  - level = {1'b0,last}+1, computed at ADDR_W+1 bits so 64 is representable.

Decomposition:
- Shared package simon_pkg: PAT_W, ADDR_W, DEPTH; LED mode constants (INPUT 3'b001, PLAYBACK 3'b010, REPEAT 3'b100, DONE 3'b111), moved from the control into the package.
- One sub-module, simon_regfile: DEPTH x PAT_W, one synchronous write port (we, waddr, wdata), two asynchronous read ports (raddr0/rdata0 for compare, raddr1/rdata1 for LEDs; both driven by i).
- Pointers, one-hot check and muxing stay in simon_datapath.

Test Plan:
- Reset then hold (rst=0 mid-run with last=5, i=3) -> last=0, i=0, i_lt_last=0, arr_full=0, level=1 immediately, before next clk edge.
- legal: pattern=4'b0100 -> legal=1; pattern=4'b0110 -> 0; pattern=4'b0000 -> 0. With mem_ld=1 and pattern=4'b0110, entry 0 is unchanged.
- Sequence build: write 4'b0001 at last=0; last_inc; write 4'b1000 at last=1. With s_led_eq_pat=0, i_inc pulses give pattern_leds 0001, 1000, then 0001 (i wraps 1->0); i_lt_last goes 1,0,1.
- Compare: mem={0010,0100}, last=1, i=1, pattern=0100 -> correct_pat=1, i_lt_last=0. Assert i_inc+last_inc together -> next cycle i=0, last=2, level=3.
- Priority: i=3, i_clr=1 and i_inc=1 same cycle -> i=0.
- Full boundary: 63 last_inc pulses -> last=63, arr_full=1, level=64. A 64th last_inc -> last stays 63. i_inc at i=63 -> i=0.
